// File: rtl/tbl_lookup_pipe.sv
// Writable lookup table with NCH independent registered read channels.
// Bulk or single-entry load; 1-cycle read latency with valid/ready backpressure.
module tbl_lookup_pipe #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 32,
  parameter  int NCH   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_en,
  input  logic [DEPTH*WIDTH-1:0] ld_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NCH-1:0]         rd_valid,
  output logic [NCH-1:0]         rd_ready,
  input  logic [NCH*AW-1:0]      rd_addr,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [NCH-1:0]         out_err
);

  // Wide enough that the slice base for entry DEPTH-1 never wraps.
  localparam int IW = AW + $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]     r_tbl [DEPTH];
  logic [NCH-1:0]       r_out_valid;
  logic [NCH-1:0]       r_out_err;
  logic [NCH*WIDTH-1:0] r_out_data;

  logic [AW-1:0]        w_addr     [NCH];
  logic [WIDTH-1:0]     w_sel      [NCH];
  logic [NCH-1:0]       w_in_range;
  logic [NCH-1:0]       w_accept;
  logic                 w_wr_ok;

  function automatic logic [IW-1:0] slice_base(input logic [AW-1:0] a);
    return IW'(a) * IW'(WIDTH);
  endfunction

  assign rd_ready  = {NCH{rst_n}} & (~r_out_valid | out_ready);
  assign w_accept  = rd_valid & rd_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  // Write-first bypass: a same-cycle load or write is visible to the read.
  always_comb begin
    w_wr_ok = IW'(wr_addr) < IW'(DEPTH);
    for (int c = 0; c < NCH; c++) begin
      w_addr[c]     = rd_addr[c*AW +: AW];
      w_sel[c]      = '0;
      w_in_range[c] = IW'(w_addr[c]) < IW'(DEPTH);
      if (w_in_range[c]) begin
        if (ld_en)
          w_sel[c] = ld_data[slice_base(w_addr[c]) +: WIDTH];
        else if (wr_en && (wr_addr == w_addr[c]))
          w_sel[c] = wr_data;
        else
          w_sel[c] = r_tbl[w_addr[c]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
      r_out_valid <= '0;
      r_out_err   <= '0;
      r_out_data  <= '0;
    end else begin
      if (ld_en) begin
        for (int i = 0; i < DEPTH; i++) r_tbl[i] <= ld_data[i*WIDTH +: WIDTH];
      end else if (wr_en && w_wr_ok) begin
        r_tbl[wr_addr] <= wr_data;
      end
      for (int c = 0; c < NCH; c++) begin
        if (w_accept[c]) begin
          r_out_valid[c]               <= 1'b1;
          r_out_data[c*WIDTH +: WIDTH] <= w_sel[c];
          r_out_err[c]                 <= ~w_in_range[c];
        end else if (out_ready[c]) begin
          r_out_valid[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tbl_lookup_pipe.sv
// Scoreboard bench: read tasks push expected beats, a negedge monitor pops and compares.
module tb_tbl_lookup_pipe;
  localparam int W = 20;
  localparam int D = 32;
  localparam int N = 2;
  localparam int A = 5;
  localparam int D2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           ld_en;
  logic [D*W-1:0] ld_data;
  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic [N-1:0]   rd_valid, rd_ready, out_valid, out_ready, out_err;
  logic [N*A-1:0] rd_addr;
  logic [N*W-1:0] out_data;

  logic            d_ld_en;
  logic [D2*W-1:0] d_ld_data;
  logic            d_wr_en;
  logic [A-1:0]    d_wr_addr;
  logic [W-1:0]    d_wr_data;
  logic            d_rd_valid, d_rd_ready, d_out_valid, d_out_ready, d_out_err;
  logic [A-1:0]    d_rd_addr;
  logic [W-1:0]    d_out_data;

  tbl_lookup_pipe #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_data(ld_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  tbl_lookup_pipe #(.WIDTH(W), .DEPTH(D2), .NCH(1)) dut20 (
    .clk(clk), .rst_n(rst_n), .ld_en(d_ld_en), .ld_data(d_ld_data),
    .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .rd_valid(d_rd_valid), .rd_ready(d_rd_ready), .rd_addr(d_rd_addr),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_err(d_out_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W:0] q0[$], q1[$], q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur, expected it", nm);
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    if (out_valid[0] && out_ready[0]) begin
      if (q0.size() == 0) miss("ch0 beat had no expectation");
      else begin e = q0.pop_front(); chk("ch0 beat {err,data}", {out_err[0], out_data[W-1:0]}, e); end
    end
    if (out_valid[1] && out_ready[1]) begin
      if (q1.size() == 0) miss("ch1 beat had no expectation");
      else begin e = q1.pop_front(); chk("ch1 beat {err,data}", {out_err[1], out_data[2*W-1:W]}, e); end
    end
    if (d_out_valid && d_out_ready) begin
      if (q2.size() == 0) miss("d20 beat had no expectation");
      else begin e = q2.pop_front(); chk("d20 beat {err,data}", {d_out_err, d_out_data}, e); end
    end
  end

  task automatic rd(input int c, input int addr, input logic [W-1:0] d, input logic e);
    int n = 0;
    rd_valid[c] = 1'b1;
    rd_addr[c*A +: A] = addr[A-1:0];
    @(negedge clk);
    while (!rd_ready[c] && n < 50) begin n++; @(negedge clk); end
    if (!rd_ready[c]) miss("rd accept timeout");
    else if (c == 0) q0.push_back({e, d});
    else q1.push_back({e, d});
    @(posedge clk); #1;
    rd_valid[c] = 1'b0;
    chk("latency out_valid", 32'(out_valid[c]), 32'd1);
  endtask

  task automatic rd20(input int addr, input logic [W-1:0] d, input logic e);
    int n = 0;
    d_rd_valid = 1'b1;
    d_rd_addr  = addr[A-1:0];
    @(negedge clk);
    while (!d_rd_ready && n < 50) begin n++; @(negedge clk); end
    if (!d_rd_ready) miss("d20 rd accept timeout");
    else q2.push_back({e, d});
    @(posedge clk); #1;
    d_rd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    time t0;
    rst_n = 1'b0; ld_en = 1'b0; ld_data = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = '0; rd_addr = '0; out_ready = 2'b11;
    d_ld_en = 1'b0; d_ld_data = '0; d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    d_rd_valid = 1'b0; d_rd_addr = '0; d_out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("reset rd_ready", 32'(rd_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset out_data lo", out_data[W-1:0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // After reset every entry reads 0, one result per cycle.
    t0 = $time;
    for (int a = 0; a < D; a++) rd(0, a, '0, 1'b0);
    chk("ch0 throughput cycles", 32'(($time - t0) / 10), 32'd32);

    // Bulk load entry i = 3i+1; same-cycle read and write see the load.
    for (int i = 0; i < D; i++) ld_data[i*W +: W] = W'(i * 3 + 1);
    ld_en = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 20'h55555;
    rd(0, 7, 20'd22, 1'b0);
    ld_en = 1'b0; wr_en = 1'b0; ld_data = '0;
    fork
      rd(0, 31, 20'd94, 1'b0);
      rd(1, 0, 20'd1, 1'b0);
    join
    rd(1, 9, 20'd28, 1'b0);

    // Single write with bypass to both channels on the same address.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 20'hABCDE;
    fork
      rd(0, 5, 20'hABCDE, 1'b0);
      rd(1, 5, 20'hABCDE, 1'b0);
    join
    wr_en = 1'b0;
    rd(1, 5, 20'hABCDE, 1'b0);

    // Backpressure on ch0 while ch1 keeps flowing.
    out_ready[0] = 1'b0;
    rd(0, 10, 20'd31, 1'b0);
    fork
      rd(0, 11, 20'd34, 1'b0);
      begin rd(1, 1, 20'd4, 1'b0); rd(1, 2, 20'd7, 1'b0); rd(1, 3, 20'd10, 1'b0); end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp out_valid0", 32'(out_valid[0]), 32'd1);
          chk("bp out_data0", out_data[W-1:0], 32'd31);
          chk("bp rd_ready0", 32'(rd_ready[0]), 32'd0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp q0 drained", q0.size(), 32'd0);
    chk("bp q1 drained", q1.size(), 32'd0);

    // DEPTH=20 instance: out-of-range read and dropped write.
    d_wr_en = 1'b1; d_wr_addr = 5'd3;  d_wr_data = 20'h00123;
    @(posedge clk); #1;
    d_wr_addr = 5'd19; d_wr_data = 20'h77777;
    @(posedge clk); #1;
    d_wr_addr = 5'd25; d_wr_data = 20'hFFFFF;
    @(posedge clk); #1;
    d_wr_en = 1'b0;
    rd20(25, 20'd0, 1'b1);
    rd20(3, 20'h00123, 1'b0);
    rd20(19, 20'h77777, 1'b0);
    rd20(9, 20'd0, 1'b0);
    rd20(5, 20'd0, 1'b0);

    // Reset with a held result in flight; a request offered during reset is ignored.
    out_ready[0] = 1'b0;
    rd(0, 4, 20'd13, 1'b0);
    rst_n = 1'b0;
    q0.delete();
    rd_valid[1] = 1'b1; rd_addr[2*A-1:A] = 5'd2;
    @(negedge clk);
    chk("rst rd_ready", 32'(rd_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rst rd_ready hold", 32'(rd_ready), 32'd0);
    rd_valid[1] = 1'b0;
    out_ready = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    fork
      rd(0, 31, 20'd0, 1'b0);
      rd(1, 10, 20'd0, 1'b0);
    join
    rd(0, 5, 20'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("final q0 empty", q0.size(), 32'd0);
    chk("final q1 empty", q1.size(), 32'd0);
    chk("final q2 empty", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
